// File: rtl/dual_port_ram.sv
// True dual-port synchronous RAM, one shared clock, registered read data.
// Port B wins same-address write collisions; cross-port reads see old data.
module dual_port_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic [ADDR_WIDTH-1:0] ad_a,
  input  logic                  wre_a,
  output logic [DATA_WIDTH-1:0] q_a,
  input  logic [DATA_WIDTH-1:0] data_b,
  input  logic [ADDR_WIDTH-1:0] ad_b,
  input  logic                  wre_b,
  output logic [DATA_WIDTH-1:0] q_b
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Reset clears only the read registers; the array keeps its contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_a <= '0;
      q_b <= '0;
    end else begin
      q_a <= wre_a ? data_a : mem[ad_a];
      q_b <= wre_b ? data_b : mem[ad_b];
      if (wre_a) mem[ad_a] <= data_a;
      // Later assignment gives port B priority on a shared address.
      if (wre_b) mem[ad_b] <= data_b;
    end
  end

endmodule

// File: tb/tb_dual_port_ram.sv
// Randomized scoreboard bench for dual_port_ram.
// Expected read data comes from a simple array model of the RAM.
module tb_dual_port_ram;

  logic       clk = 0;
  logic       rst_n = 0;
  logic [7:0] data_a = 0, data_b = 0;
  logic [5:0] ad_a = 0, ad_b = 0;
  logic       wre_a = 0, wre_b = 0;
  logic [7:0] q_a, q_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] ea;
    logic [7:0] eb;
    bit         ka;
    bit         kb;
  } exp_t;

  exp_t sbq[$];

  logic [7:0] model [64];
  bit         known [64];

  dual_port_ram dut (
    .clk(clk), .rst_n(rst_n),
    .data_a(data_a), .ad_a(ad_a), .wre_a(wre_a), .q_a(q_a),
    .data_b(data_b), .ad_b(ad_b), .wre_b(wre_b), .q_b(q_b)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic access(bit wa, int aa, logic [7:0] da,
                        bit wb, int ab, logic [7:0] db);
    exp_t e;
    @(negedge clk);
    wre_a = wa; ad_a = 6'(aa); data_a = da;
    wre_b = wb; ad_b = 6'(ab); data_b = db;
    e.ea = wa ? da : model[aa];
    e.ka = wa || known[aa];
    e.eb = wb ? db : model[ab];
    e.kb = wb || known[ab];
    sbq.push_back(e);
    if (wa) begin model[aa] = da; known[aa] = 1; end
    if (wb) begin model[ab] = db; known[ab] = 1; end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        if (e.ka) check("q_a", q_a, e.ea);
        if (e.kb) check("q_b", q_b, e.eb);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int aa, ab;
    for (int i = 0; i < 64; i++) known[i] = 0;
    #3;
    check("reset_q_a", q_a, 8'h00);
    check("reset_q_b", q_b, 8'h00);
    @(negedge clk);
    rst_n = 1;

    access(1, 2, 8'h22, 1, 1, 8'h34);
    access(1, 3, 8'h45, 0, 1, 8'h00);
    access(0, 2, 8'h00, 0, 3, 8'h00);
    access(0, 1, 8'h00, 1, 2, 8'h77);
    access(0, 2, 8'h00, 0, 3, 8'h00);
    access(1, 5, 8'h11, 1, 5, 8'h99);
    access(0, 5, 8'h00, 0, 5, 8'h00);
    access(1, 7, 8'hAA, 0, 2, 8'h00);
    access(1, 7, 8'h55, 0, 7, 8'h00);
    access(0, 3, 8'h00, 0, 7, 8'h00);

    @(negedge clk);
    @(negedge clk);
    wre_a = 0; wre_b = 0;
    #2 rst_n = 0;
    #1;
    check("async_rst_q_a", q_a, 8'h00);
    check("async_rst_q_b", q_b, 8'h00);
    @(posedge clk);
    #1;
    check("held_rst_q_a", q_a, 8'h00);
    check("held_rst_q_b", q_b, 8'h00);
    @(negedge clk);
    rst_n = 1;

    access(0, 1, 8'h00, 0, 2, 8'h00);
    access(0, 5, 8'h00, 0, 7, 8'h00);

    for (int n = 0; n < 600; n++) begin
      aa = int'($urandom_range(0, 63));
      ab = ($urandom_range(0, 3) == 0) ? aa : int'($urandom_range(0, 63));
      access(bit'($urandom_range(0, 1)), aa, 8'($urandom),
             bit'($urandom_range(0, 1)), ab, 8'($urandom));
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
